// File: rtl/lpif_sched_pkg.sv
// Shared definitions for the LPIF downstream flit scheduler: link-state codes,
// scheduler FSM states and the CRC-4 (x^4+x+1) single-bit update.
package lpif_sched_pkg;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned LS_W  = 4;
    localparam int unsigned CRC_W = 4;

    localparam logic [LS_W-1:0] RESET     = 4'h0;
    localparam logic [LS_W-1:0] ACTIVE    = 4'h1;
    localparam logic [LS_W-1:0] LINKRESET = 4'h9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } sched_state_e;

    // One MSB-first step of CRC-4, polynomial x^4+x+1.
    function automatic logic [CRC_W-1:0] crc4_bit(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction

endpackage

// File: rtl/lpif_rr_arb.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr+1 (mod NUM_REQ); returns one-hot grant and binary index.
module lpif_rr_arb
    import lpif_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        found = 1'b0;
        j     = '0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            j = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/lpif_dstrm_sched.sv
// LPIF downstream flit scheduler: round-robin with packet locking onto the
// single dstrm_* lane. Optional CRC-4 generation under `LPIF_DSTRM_CRC_EN.
module lpif_dstrm_sched
    import lpif_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 128
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    input  logic [LS_W-1:0]           link_state,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_ready,
    output logic [LS_W-1:0]           dstrm_state,
    output logic [IDX_W-1:0]          dstrm_protid,
    output logic [DATA_W-1:0]         dstrm_data,
    output logic                      dstrm_dvalid,
    output logic [CRC_W-1:0]          dstrm_crc,
    output logic                      dstrm_crc_valid,
    output logic                      dstrm_valid,
    output logic                      busy
);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] owner_mask, arb_req, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               load_c, link_up_c, accept_c, last_c;
    logic [DATA_W-1:0]  sel_data;

    logic [LS_W-1:0]    lstate_q;
    logic [IDX_W-1:0]   protid_q;
    logic [DATA_W-1:0]  data_q;
    logic               dvalid_q, valid_q;

    assign load_c    = tx_ready | ~dvalid_q;
    assign link_up_c = (link_state == ACTIVE);

    // Winner's flit/last and the owner's request mask.
    always_comb begin
        sel_data   = '0;
        last_c     = 1'b0;
        owner_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            owner_mask[i] = (owner_q == IDX_W'(i));
            if (arb_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                last_c   = req_last[i];
            end
        end
    end

    assign arb_req = (state_q == LOCK) ? (req_valid & owner_mask) : req_valid;

    lpif_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // valid_q qualifies grants so nothing is accepted while in reset.
    assign req_ready = arb_gnt & {NUM_REQ{load_c & link_up_c & valid_q}};
    assign accept_c  = |req_ready;

    // Next-state: lock on a non-last flit, release on owner's last or link reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (last_c) begin
                        ptr_d = arb_idx;
                    end else begin
                        state_d = LOCK;
                        owner_d = arb_idx;
                    end
                end
            end
            LOCK: begin
                if (link_state == RESET || link_state == LINKRESET) begin
                    state_d = IDLE;
                end else if (accept_c && last_c) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            busy_q  <= (state_d == LOCK);
        end
    end

    // Output register: loads when empty or drained, otherwise holds.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            lstate_q <= '0;
            valid_q  <= 1'b0;
            dvalid_q <= 1'b0;
            protid_q <= '0;
            data_q   <= '0;
        end else begin
            lstate_q <= link_state;
            valid_q  <= 1'b1;
            if (load_c) begin
                dvalid_q <= accept_c;
                if (accept_c) begin
                    data_q   <= sel_data;
                    protid_q <= arb_idx;
                end
            end
        end
    end

`ifdef LPIF_DSTRM_CRC_EN
    logic [CRC_W-1:0] crc_c, crc_q;

    always_comb begin
        crc_c = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            crc_c = crc4_bit(crc_c, sel_data[i]);
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            crc_q <= '0;
        end else if (load_c && accept_c) begin
            crc_q <= crc_c;
        end
    end

    assign dstrm_crc       = crc_q;
    assign dstrm_crc_valid = dvalid_q;
`else
    assign dstrm_crc       = '0;
    assign dstrm_crc_valid = 1'b0;
`endif

    assign dstrm_state  = lstate_q;
    assign dstrm_protid = protid_q;
    assign dstrm_data   = data_q;
    assign dstrm_dvalid = dvalid_q;
    assign dstrm_valid  = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lpif_dstrm_sched.sv
// Scoreboard bench for lpif_dstrm_sched: requester queues feed the DUT, the
// expected output flit order is pushed by hand, a negedge monitor pops/compares.
module tb_lpif_dstrm_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } flit_t;

    typedef struct packed {
        logic [1:0]    protid;
        logic [DW-1:0] data;
        logic [3:0]    crc;
    } exp_t;

`ifdef LPIF_DSTRM_CRC_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic             clk_wr     = 1'b0;
    logic             rst_wr_n   = 1'b0;
    logic [3:0]       link_state = 4'h1;
    logic [NR-1:0]    req_valid  = '0;
    logic [NR*DW-1:0] req_data   = '0;
    logic [NR-1:0]    req_last   = '0;
    logic             tx_ready   = 1'b1;
    logic [NR-1:0]    req_ready;
    logic [3:0]       dstrm_state;
    logic [1:0]       dstrm_protid;
    logic [DW-1:0]    dstrm_data;
    logic             dstrm_dvalid;
    logic [3:0]       dstrm_crc;
    logic             dstrm_crc_valid;
    logic             dstrm_valid;
    logic             busy;

    flit_t         rq [NR][$];
    exp_t          exp_q[$];
    int            pop_log[$];
    logic [NR-1:0] rdy_snap = '0;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            busy_cnt = 0;

    localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] PAT_5A = {16{8'h5A}};
    localparam logic [DW-1:0] PAT_C3 = {16{8'hC3}};

    lpif_dstrm_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk_wr          (clk_wr),
        .rst_wr_n        (rst_wr_n),
        .link_state      (link_state),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .tx_ready        (tx_ready),
        .dstrm_state     (dstrm_state),
        .dstrm_protid    (dstrm_protid),
        .dstrm_data      (dstrm_data),
        .dstrm_dvalid    (dstrm_dvalid),
        .dstrm_crc       (dstrm_crc),
        .dstrm_crc_valid (dstrm_crc_valid),
        .dstrm_valid     (dstrm_valid),
        .busy            (busy)
    );

    always #5 clk_wr = ~clk_wr;

    // Reference CRC: remainder of data(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [DW-1:0] d);
        logic [DW+3:0] r;
        r = {d, 4'b0000};
        for (int i = DW + 3; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [DW-1:0] mk(input int r, input int s);
        logic [DW-1:0] d;
        d            = '0;
        d[DW-1 -: 8] = 8'(r);
        d[63:56]     = 8'h5C;
        d[7:0]       = 8'(s);
        return d;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic push_flit(input int r, input logic [DW-1:0] d, input logic last);
        flit_t f;
        f.data = d;
        f.last = last;
        rq[r].push_back(f);
    endtask

    task automatic expect_flit(input logic [1:0] pid, input logic [DW-1:0] d);
        exp_t e;
        e.protid = pid;
        e.data   = d;
        e.crc    = CRC_ON ? ref_crc(d) : 4'h0;
        exp_q.push_back(e);
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0);
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 300) begin
            @(posedge clk_wr);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_drain got_left=%0d want=0", name, exp_q.size());
        end
        repeat (3) @(posedge clk_wr);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk_wr);
            #1;
            n++;
        end while (!busy && n < 30);
        chk({name, "_busy_seen"}, DW'(busy), DW'(1'b1));
    endtask

    task automatic wait_data(input string name, input logic [DW-1:0] d);
        int n;
        n = 0;
        do begin
            @(posedge clk_wr);
            #1;
            n++;
        end while (!(dstrm_dvalid && dstrm_data == d) && n < 30);
        chk({name, "_seen"}, dstrm_data, d);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_dvalid"},    DW'(dstrm_dvalid),    DW'(0));
        chk({name, "_protid"},    DW'(dstrm_protid),    DW'(0));
        chk({name, "_data"},      dstrm_data,           DW'(0));
        chk({name, "_busy"},      DW'(busy),            DW'(0));
        chk({name, "_valid"},     DW'(dstrm_valid),     DW'(0));
        chk({name, "_state"},     DW'(dstrm_state),     DW'(0));
        chk({name, "_crc"},       DW'(dstrm_crc),       DW'(0));
        chk({name, "_crc_valid"}, DW'(dstrm_crc_valid), DW'(0));
        chk({name, "_req_ready"}, DW'(req_ready),       DW'(0));
    endtask

    // Requester model: pop what was granted, then present the queue heads.
    initial begin : driver
        forever begin
            @(posedge clk_wr);
            for (int i = 0; i < NR; i++) begin
                if (rdy_snap[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            #1;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_data[i*DW +: DW]    = rq[i][0].data;
                    req_last[i]             = rq[i][0].last;
                end else begin
                    req_valid[i]            = 1'b0;
                    req_last[i]             = 1'b0;
                end
            end
        end
    end

    // Monitor: one scoreboard pop per flit transferred (dvalid & tx_ready).
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_wr);
            cyc++;
            rdy_snap = req_ready;
            chk("ready_onehot", DW'($countones(req_ready) <= 1), DW'(1'b1));
            if (busy) busy_cnt++;
            if (!dstrm_dvalid) chk("crc_valid_idle", DW'(dstrm_crc_valid), DW'(0));
            if (dstrm_dvalid && tx_ready) begin
                pop_log.push_back(cyc);
                chk("crc_valid_flit", DW'(dstrm_crc_valid), DW'(CRC_ON));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_flit got_protid=%0d got_data=%0h want=none",
                             dstrm_protid, dstrm_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("protid", DW'(dstrm_protid), DW'(e.protid));
                    chk("data",   dstrm_data,        e.data);
                    chk("crc",    DW'(dstrm_crc),    DW'(e.crc));
                end
            end
        end
    end

    initial begin : main
        repeat (2) @(posedge clk_wr);
        #1;
        check_zero("reset");
        rst_wr_n = 1'b1;
        #1;
        chk("valid_before_clk", DW'(dstrm_valid), DW'(0));
        @(posedge clk_wr);
        #1;
        chk("valid_after_clk", DW'(dstrm_valid), DW'(1));
        chk("state_reg", DW'(dstrm_state), DW'(4'h1));

        // Arbitration order with all four requesters streaming single flits.
        pop_log.delete();
        for (int s = 0; s < 2; s++) for (int r = 0; r < 4; r++) push_flit(r, mk(r, s), 1'b1);
        for (int s = 0; s < 2; s++) for (int r = 0; r < 4; r++) expect_flit(2'(r), mk(r, s));
        wait_drain("t1");
        chk("t1_pops", DW'(pop_log.size()), DW'(8));
        if (pop_log.size() >= 8) chk("t1_span", DW'(pop_log[7] - pop_log[0]), DW'(7));

        // Move the pointer to requester 0, then a locked 3-flit packet from 1.
        push_flit(0, mk(0, 7), 1'b1);
        expect_flit(2'd0, mk(0, 7));
        wait_drain("t2pre");
        busy_cnt = 0;
        push_flit(1, mk(1, 0), 1'b0);
        push_flit(1, mk(1, 1), 1'b0);
        push_flit(1, mk(1, 2), 1'b1);
        push_flit(0, mk(0, 8), 1'b1);
        push_flit(2, mk(2, 8), 1'b1);
        push_flit(3, mk(3, 8), 1'b1);
        expect_flit(2'd1, mk(1, 0));
        expect_flit(2'd1, mk(1, 1));
        expect_flit(2'd1, mk(1, 2));
        expect_flit(2'd2, mk(2, 8));
        expect_flit(2'd3, mk(3, 8));
        expect_flit(2'd0, mk(0, 8));
        wait_drain("t2");
        chk("t2_busy_cycles", DW'(busy_cnt), DW'(2));

        // Backpressure: hold A5 pattern for five cycles.
        push_flit(2, PAT_A5, 1'b1);
        push_flit(2, PAT_5A, 1'b1);
        push_flit(2, PAT_C3, 1'b1);
        expect_flit(2'd2, PAT_A5);
        expect_flit(2'd2, PAT_5A);
        expect_flit(2'd2, PAT_C3);
        wait_data("t3", PAT_A5);
        tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk_wr);
            chk("t3_hold_data",   dstrm_data,          PAT_A5);
            chk("t3_hold_dvalid", DW'(dstrm_dvalid),   DW'(1));
            chk("t3_ready_low",   DW'(req_ready),      DW'(0));
        end
        @(posedge clk_wr);
        #1;
        tx_ready = 1'b1;
        wait_drain("t3");

        // Link stall mid-packet keeps the lock; packet resumes from the owner.
        for (int s = 0; s < 3; s++) push_flit(3, mk(3, s), (s == 2));
        push_flit(0, mk(0, 9), 1'b1);
        for (int s = 0; s < 3; s++) expect_flit(2'd3, mk(3, s));
        expect_flit(2'd0, mk(0, 9));
        wait_busy("t4a");
        link_state = 4'h4;
        repeat (3) begin
            @(negedge clk_wr);
            chk("t4a_busy_held", DW'(busy),      DW'(1));
            chk("t4a_no_grant",  DW'(req_ready), DW'(0));
        end
        chk("t4a_state_reg", DW'(dstrm_state), DW'(4'h4));
        @(posedge clk_wr);
        #1;
        link_state = 4'h1;
        wait_drain("t4a");

        // LINKRESET pulse drops the lock; pointer order is unchanged.
        for (int s = 0; s < 3; s++) push_flit(1, mk(1, s), (s == 2));
        push_flit(2, mk(2, 5), 1'b1);
        for (int s = 0; s < 3; s++) expect_flit(2'd1, mk(1, s));
        expect_flit(2'd2, mk(2, 5));
        wait_busy("t4b");
        link_state = 4'h9;
        @(posedge clk_wr);
        #1;
        link_state = 4'h1;
        chk("t4b_busy_dropped", DW'(busy), DW'(0));
        wait_drain("t4b");

        // Asynchronous reset during LOCK.
        for (int s = 4; s < 7; s++) push_flit(3, mk(3, s), (s == 6));
        wait_busy("t5");
        rst_wr_n = 1'b0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        #1;
        check_zero("t5_rst");
        repeat (2) @(posedge clk_wr);
        #1;
        rst_wr_n = 1'b1;
        #1;
        chk("t5_valid_before_clk", DW'(dstrm_valid), DW'(0));
        @(posedge clk_wr);
        #1;
        chk("t5_valid_after_clk", DW'(dstrm_valid), DW'(1));
        push_flit(3, mk(3, 7), 1'b1);
        push_flit(0, mk(0, 7), 1'b1);
        expect_flit(2'd0, mk(0, 7));
        expect_flit(2'd3, mk(3, 7));
        wait_drain("t5");

        // CRC of data 128'h1 (x^4 mod x^4+x+1 = 4'h3) when enabled.
        push_flit(1, DW'(1), 1'b1);
        expect_flit(2'd1, DW'(1));
        wait_data("t6", DW'(1));
        chk("t6_crc",       DW'(dstrm_crc),       CRC_ON ? DW'(4'h3) : DW'(0));
        chk("t6_crc_valid", DW'(dstrm_crc_valid), DW'(CRC_ON));
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
